// File: rtl/da_fir_sequencer_pkg.sv
// Shared types and helpers for the distributed-arithmetic FIR sequencer.
//   seq_state_t : sequencer FSM encoding
//   steps()     : number of accumulate steps (bit-slices) per sample
package da_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic int steps(input int word_width, input int slice_width);
        return word_width / slice_width;
    endfunction

endpackage

// File: rtl/da_fir_sequencer_slice_counter.sv
// Bit-slice index counter for the DA accumulate phase.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clr   : load zero (takes priority over inc)
//   inc   : advance one slice
//   cnt   : current slice index
//   last  : cnt is the final (sign) slice
module da_slice_counter #(
    parameter int STEPS = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(STEPS - 1));

    // Saturates on the last slice so the index stays put after the
    // accumulate phase; LOAD always clears it before the next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/da_fir_sequencer.sv
// Handshaked scheduler for the distributed-arithmetic FIR datapath.
// Accepts one sample, issues a load cycle and one accumulate cycle per
// bit-slice (LSB first, sign slice subtracted), then holds the result valid
// until the consumer takes it.
//   clk, rst              : clock / synchronous active-high reset
//   en                    : global enable, 0 freezes everything
//   in_valid/in_ready     : sample handshake, in_data is the sample
//   x_out, x_we           : registered sample and delay-line shift strobe
//   acc_clr/en/sub        : accumulator clear / accumulate / subtract
//   slice_sel             : slice index being accumulated
//   res_cap               : capture accumulator into the output register
//   out_valid/out_ready   : result handshake
//   busy                  : not idle
//
// state | meaning
// IDLE  | waiting for a sample
// LOAD  | shift sample into delay line, clear accumulator
// ACCUM | one bit-slice per cycle, result captured on the last
// DONE  | result valid, waiting for the consumer
module da_fir_sequencer
    import da_ctrl_pkg::*;
#(
    parameter  int WORD_WIDTH  = 16,
    parameter  int SLICE_WIDTH = 4,
    localparam int STEPS       = steps(WORD_WIDTH, SLICE_WIDTH),
    localparam int SEL_W       = $clog2(STEPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic [WORD_WIDTH-1:0] x_out,
    output logic                  x_we,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic                  acc_sub,
    output logic [SEL_W-1:0]      slice_sel,
    output logic                  res_cap,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    if ((WORD_WIDTH % SLICE_WIDTH) != 0 || STEPS < 2) begin : g_bad_params
        $error("da_fir_sequencer: WORD_WIDTH must be a multiple of SLICE_WIDTH with at least 2 slices");
    end

    seq_state_t       state, state_nxt;
    logic             accept;
    logic             last_slice;
    logic [SEL_W-1:0] slice_cnt;

    da_slice_counter #(
        .STEPS (STEPS),
        .CNT_W (SEL_W)
    ) u_slice_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (en && state == LOAD),
        .inc  (en && state == ACCUM),
        .cnt  (slice_cnt),
        .last (last_slice)
    );

    // in_ready is held low during reset so nothing is accepted that the
    // reset would immediately discard.
    always_comb begin
        in_ready = 1'b0;
        if (en && !rst) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                DONE:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                x_out <= in_data;
            end
        end
    end

    // The result transfer is also qualified by en: a frozen sequencer does
    // not consume out_ready.
    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE:    if (accept) state_nxt = LOAD;
                LOAD:    state_nxt = ACCUM;
                ACCUM:   if (last_slice) state_nxt = DONE;
                DONE: begin
                    if (accept)         state_nxt = LOAD;
                    else if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        x_we      = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        acc_sub   = 1'b0;
        res_cap   = 1'b0;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        slice_sel = slice_cnt;
        if (en) begin
            case (state)
                LOAD: begin
                    x_we    = 1'b1;
                    acc_clr = 1'b1;
                end
                ACCUM: begin
                    acc_en  = 1'b1;
                    acc_sub = last_slice;
                    res_cap = last_slice;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_da_fir_sequencer.sv
module tb_da_fir_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, x_we, acc_clr, acc_en, acc_sub, res_cap, out_valid, busy;
    logic [15:0] x_out;
    logic [1:0]  slice_sel;

    logic        in_ready2, x_we2, acc_clr2, acc_en2, acc_sub2, res_cap2, out_valid2, busy2;
    logic [15:0] x_out2;
    logic [0:0]  slice_sel2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    da_fir_sequencer #(.WORD_WIDTH(16), .SLICE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .x_out(x_out), .x_we(x_we), .acc_clr(acc_clr),
        .acc_en(acc_en), .acc_sub(acc_sub), .slice_sel(slice_sel), .res_cap(res_cap),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    da_fir_sequencer #(.WORD_WIDTH(16), .SLICE_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .x_out(x_out2), .x_we(x_we2), .acc_clr(acc_clr2),
        .acc_en(acc_en2), .acc_sub(acc_sub2), .slice_sel(slice_sel2), .res_cap(res_cap2),
        .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2)
    );

    // {x_we, acc_clr, acc_en, acc_sub, res_cap, out_valid, in_ready, busy}
    wire [7:0] obs  = {x_we, acc_clr, acc_en, acc_sub, res_cap, out_valid, in_ready, busy};
    wire [7:0] obs2 = {x_we2, acc_clr2, acc_en2, acc_sub2, res_cap2, out_valid2, in_ready2, busy2};

    localparam logic [7:0] S_ZERO  = 8'b0000_0000;
    localparam logic [7:0] S_IDLE  = 8'b0000_0010;
    localparam logic [7:0] S_LOAD  = 8'b1100_0001;
    localparam logic [7:0] S_ACC   = 8'b0010_0001;
    localparam logic [7:0] S_LAST  = 8'b0011_1001;
    localparam logic [7:0] S_DONE  = 8'b0000_0101;
    localparam logic [7:0] S_DONER = 8'b0000_0111;
    localparam logic [7:0] S_STALL = 8'b0000_0001;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        @(negedge clk);
        checks++;
        if (obs !== S_ZERO || x_out !== 16'h0 || slice_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_state obs=%b x_out=%h sel=%0d want obs=%b x_out=0000 sel=0", obs, x_out, slice_sel, S_ZERO);
        end
        step();
        rst = 1'b0; en = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (obs !== S_ZERO) begin
            errors++;
            $display("FAIL idle_en0_ready obs=%b want %b", obs, S_ZERO);
        end
        step();
        @(negedge clk);
        checks++;
        if (obs !== S_ZERO || x_out !== 16'h0) begin
            errors++;
            $display("FAIL idle_en0_no_accept obs=%b x_out=%h want obs=%b x_out=0000", obs, x_out, S_ZERO);
        end
    endtask

    task automatic test_single();
        step();
        en = 1'b1; in_valid = 1'b1; in_data = 16'hB3C1;
        @(negedge clk);
        checks++;
        if (obs !== S_IDLE) begin
            errors++;
            $display("FAIL single_accept obs=%b want %b", obs, S_IDLE);
        end
        step();
        in_valid = 1'b0; in_data = 16'h0000;
        @(negedge clk);
        checks++;
        if (obs !== S_LOAD || x_out !== 16'hB3C1) begin
            errors++;
            $display("FAIL single_load obs=%b x_out=%h want obs=%b x_out=b3c1", obs, x_out, S_LOAD);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            checks++;
            if (obs !== ((k == 3) ? S_LAST : S_ACC) || slice_sel !== 2'(k)) begin
                errors++;
                $display("FAIL single_accum_%0d obs=%b sel=%0d want obs=%b sel=%0d", k, obs, slice_sel,
                         (k == 3) ? S_LAST : S_ACC, k);
            end
        end
        step();
        @(negedge clk);
        checks++;
        if (obs !== S_DONE || x_out !== 16'hB3C1) begin
            errors++;
            $display("FAIL single_done obs=%b x_out=%h want obs=%b x_out=b3c1", obs, x_out, S_DONE);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        step();
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obs !== S_DONE || x_out !== 16'hB3C1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold bad_cycles=%0d want 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== S_DONER) begin
            errors++;
            $display("FAIL backpressure_release obs=%b want %b", obs, S_DONER);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== S_LOAD || x_out !== 16'h1234) begin
            errors++;
            $display("FAIL backpressure_load obs=%b x_out=%h want obs=%b x_out=1234", obs, x_out, S_LOAD);
        end
        for (int k = 0; k < 4; k++) step();
        step();
        @(negedge clk);
        checks++;
        if (obs !== S_DONER) begin
            errors++;
            $display("FAIL backpressure_done obs=%b want %b", obs, S_DONER);
        end
        step();
        @(negedge clk);
        checks++;
        if (obs !== S_IDLE) begin
            errors++;
            $display("FAIL backpressure_idle obs=%b want %b", obs, S_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] samples [3];
        int a [3];
        int n = 0;
        int drained = 0;
        samples = '{16'hA001, 16'h5AA5, 16'h0FF0};
        step();
        out_ready = 1'b1; in_valid = 1'b1; in_data = samples[0];
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (n > 0) begin
                checks++;
                if (in_ready !== ((c - a[0]) % 6 == 0)) begin
                    errors++;
                    $display("FAIL b2b_in_ready cycle=%0d got=%b want=%b", c - a[0], in_ready, ((c - a[0]) % 6 == 0));
                end
                if ((c - a[0]) % 6 == 0) begin
                    checks++;
                    if (out_valid !== 1'b1 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_no_bubble cycle=%0d out_valid=%b busy=%b want 1 1", c - a[0], out_valid, busy);
                    end
                end
            end
            if (in_valid && in_ready) begin
                a[n] = c;
                n++;
            end
            step();
            if (in_valid && n > 0 && a[n-1] == c) begin
                checks++;
                if (x_we !== 1'b1 || x_out !== samples[n-1]) begin
                    errors++;
                    $display("FAIL b2b_load_%0d x_we=%b x_out=%h want 1 %h", n - 1, x_we, x_out, samples[n-1]);
                end
                if (n < 3) in_data = samples[n];
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (n != 3 || a[1] - a[0] != 6 || a[2] - a[1] != 6) begin
            errors++;
            $display("FAIL b2b_spacing accepted=%0d gaps=%0d,%0d want 3 6,6", n, a[1] - a[0], a[2] - a[1]);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && !drained; i++) begin
            @(negedge clk);
            if (busy === 1'b0) drained = 1;
            else step();
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL b2b_drain busy=%b want 0 within 12 cycles", busy);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_tab [10];
        int         sel_tab [10];
        logic       en_tab  [10];
        exp_tab = '{S_IDLE, S_LOAD, S_ACC, S_STALL, S_STALL, S_STALL, S_ACC, S_ACC, S_LAST, S_DONE};
        sel_tab = '{-1, -1, 0, 1, 1, 1, 1, 2, 3, -1};
        en_tab  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hC0DE;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                step();
                in_valid = 1'b0;
            end
            en = en_tab[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_tab[i] || (sel_tab[i] >= 0 && slice_sel !== 2'(sel_tab[i]))) begin
                errors++;
                $display("FAIL stall_T%0d obs=%b sel=%0d want obs=%b sel=%0d", i, obs, slice_sel, exp_tab[i], sel_tab[i]);
            end
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (obs !== S_IDLE) begin
            errors++;
            $display("FAIL stall_idle obs=%b want %b", obs, S_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        step();
        in_valid = 1'b1; in_data = 16'h8001;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== S_ACC || slice_sel !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_accum2 obs=%b sel=%0d want obs=%b sel=2", obs, slice_sel, S_ACC);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== S_IDLE || slice_sel !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_after obs=%b sel=%0d want obs=%b sel=0", obs, slice_sel, S_IDLE);
        end
        step();
        @(negedge clk);
        checks++;
        if (obs !== S_IDLE) begin
            errors++;
            $display("FAIL rstmid_no_cap obs=%b want %b", obs, S_IDLE);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_tab [5];
        int         sel_tab [5];
        exp_tab = '{S_IDLE, S_LOAD, S_ACC, S_LAST, S_DONE};
        sel_tab = '{-1, -1, 0, 1, -1};
        rst = 1'b1; en = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        step();
        rst = 1'b0; in_valid = 1'b1; in_data = 16'h7E81;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                step();
                in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (obs2 !== exp_tab[i] || (sel_tab[i] >= 0 && slice_sel2 !== 1'(sel_tab[i]))) begin
                errors++;
                $display("FAIL sweep_T%0d obs=%b sel=%0d want obs=%b sel=%0d", i, obs2, slice_sel2, exp_tab[i], sel_tab[i]);
            end
        end
        checks++;
        if (x_out2 !== 16'h7E81) begin
            errors++;
            $display("FAIL sweep_x_out got=%h want 7e81", x_out2);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
